// File: rtl/alu_stage_pkg.sv
// Shared definitions for the ALU issue stage.
//   ALU_DATA_W : default operand/result width
//   ALU_OP_W   : default opcode width
//   state_t    : issue FSM states
package alu_stage_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of W bits.
//   clk, rst_n : clock, synchronous active-low reset (pointers only)
//   push, wdata: write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   rdata      : head entry, combinational
//   full, empty: occupancy flags from registered pointers
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Issue stage in front of a combinational ALU.
// Buffers commands, drives registered operands to the ALU one at a time,
// captures the result and presents it with a sequence tag.
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid/in_ready          : command handshake; in_a, in_b, in_op payload
//   alu_a/alu_b/alu_op         : registered operands to the ALU
//   alu_result                 : ALU output (combinational on alu_*)
//   out_valid/out_ready        : result handshake; out_result, out_tag payload
//   busy                       : FIFO non-empty or FSM not idle
//   done_count                 : completed result handshakes, wraps
//
// state | meaning
// IDLE  | waiting for a buffered command
// EXEC  | operands stable at the ALU; result captured at the end of this cycle
// HOLD  | result presented, waiting for out_ready
module alu_cmd_issue
  import alu_stage_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy,
  output logic [15:0]       done_count
);

  localparam int CMD_W = 2*DATA_W + OP_W;
  localparam logic [TAG_W-1:0] TAG_ONE = {{(TAG_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   out_result_q, out_result_d;
  logic                out_valid_q, out_valid_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;
  logic [TAG_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [15:0]         done_count_q, done_count_d;

  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CMD_W-1:0]    fifo_rdata;
  logic                load;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({in_a, in_b, in_op}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    out_result_d = out_result_q;
    out_valid_d  = out_valid_q;
    out_tag_d    = out_tag_q;
    issue_cnt_d  = issue_cnt_q;
    done_count_d = done_count_q;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      EXEC: begin
        out_result_d = alu_result;
        out_valid_d  = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          done_count_d = done_count_q + 16'd1;
          out_valid_d  = 1'b0;
          if (!fifo_empty) load = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared by IDLE and HOLD: take the head command and start execution.
    if (load) begin
      {alu_a_d, alu_b_d, alu_op_d} = fifo_rdata;
      out_tag_d   = issue_cnt_q;
      issue_cnt_d = issue_cnt_q + TAG_ONE;
      state_d     = EXEC;
    end
  end

  assign fifo_pop = load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
      out_tag_q    <= '0;
      issue_cnt_q  <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      out_result_q <= out_result_d;
      out_valid_q  <= out_valid_d;
      out_tag_q    <= out_tag_d;
      issue_cnt_q  <= issue_cnt_d;
      done_count_q <= done_count_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign done_count = done_count_q;
  assign busy       = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_issue.sv
module tb_alu_cmd_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b, in_op;
  logic [31:0] alu_a, alu_b, alu_op, alu_result;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        busy;
  logic [15:0] done_count;

  // ALU stub: plain add, or add-then-xor-op so opcode routing is exercised too.
  logic mix;
  assign alu_result = mix ? ((alu_a + alu_b) ^ alu_op) : (alu_a + alu_b);

  always #5 clk = ~clk;

  alu_cmd_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy),
    .done_count (done_count)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  model_tag;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hs_cyc[$];
  logic        rand_or = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard producer and consumer, both observing handshakes that will
  // complete at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        e.res = mix ? ((in_a + in_b) ^ in_op) : (in_a + in_b);
        e.tag = model_tag;
        model_tag = model_tag + 4'd1;
        sb.push_back(e);
      end
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: actual=%0h tag=%0h required=none", out_result, out_tag);
        end else begin
          g = sb.pop_front();
          check("result", {32'd0, out_result}, {32'd0, g.res});
          check("tag", {60'd0, out_tag}, {60'd0, g.tag});
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_or) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    rst_n     = 1'b0;
    sb.delete();
    model_tag = 4'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op);
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", 64'd1, 64'd0);
      in_valid = 1'b0;
      step(1);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      step(1);
      n++;
    end
    check("drain_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] r_res, sa, sb_, sop;
    logic [3:0]  r_tag;
    logic        stable;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    out_ready = 1'b0;
    mix = 1'b0;
    model_tag = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_done", {48'd0, done_count}, 64'd0);
    check("rst_alu_a", {32'd0, alu_a}, 64'd0);
    check("rst_out_tag", {60'd0, out_tag}, 64'd0);

    // Single command latency
    in_valid = 1'b1; in_a = 32'd10; in_b = 32'd5; in_op = 32'd2;
    step(1);
    in_valid = 1'b0;
    check("single_ov_edge0", {63'd0, out_valid}, 64'd0);
    step(1);
    check("single_alu_a", {32'd0, alu_a}, 64'd10);
    check("single_alu_b", {32'd0, alu_b}, 64'd5);
    check("single_alu_op", {32'd0, alu_op}, 64'd2);
    check("single_ov_edge1", {63'd0, out_valid}, 64'd0);
    step(1);
    check("single_ov_edge2", {63'd0, out_valid}, 64'd1);
    check("single_result", {32'd0, out_result}, 64'd15);
    check("single_tag", {60'd0, out_tag}, 64'd0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("single_done", {48'd0, done_count}, 64'd1);
    check("single_busy", {63'd0, busy}, 64'd0);

    // Backpressure: one issued, four buffered, sixth refused
    for (int i = 0; i < 5; i++) send(32'd100 + 32'(i), 32'(i), 32'(i));
    in_a = 32'd999; in_b = 32'd1; in_op = 32'd7;
    step(3);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_busy", {63'd0, busy}, 64'd1);
    in_valid = 1'b0;
    check("bp_result", {32'd0, out_result}, 64'd100);
    check("bp_tag", {60'd0, out_tag}, 64'd1);
    r_res = out_result; r_tag = out_tag; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (out_result !== r_res || out_tag !== r_tag || out_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", {63'd0, stable}, 64'd1);

    // Full boundary: in_ready rises only after the pop edge
    out_ready = 1'b1;
    #1;
    check("full_same_cycle", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("full_after_pop", {63'd0, in_ready}, 64'd1);
    check("full_ov_drop", {63'd0, out_valid}, 64'd0);

    out_ready = 1'b1;
    wait_idle();
    out_ready = 1'b0;
    check("bp_done", {48'd0, done_count}, 64'd6);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Idle stability of ALU operands
    check("idle_alu_a", {32'd0, alu_a}, 64'd104);
    check("idle_alu_b", {32'd0, alu_b}, 64'd4);
    check("idle_alu_op", {32'd0, alu_op}, 64'd4);
    sa = alu_a; sb_ = alu_b; sop = alu_op; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (alu_a !== sa || alu_b !== sb_ || alu_op !== sop || busy !== 1'b0) stable = 1'b0;
    end
    check("idle_stable", {63'd0, stable}, 64'd1);

    // Streaming with tag wrap
    do_reset();
    check("rst2_done", {48'd0, done_count}, 64'd0);
    out_ready = 1'b1;
    hs_cyc.delete();
    for (int i = 0; i < 20; i++) send(32'(i), 32'(2*i), 32'(i));
    in_valid = 1'b0;
    wait_idle();
    check("stream_done", {48'd0, done_count}, 64'd20);
    check("stream_count", 64'(hs_cyc.size()), 64'd20);
    if (hs_cyc.size() == 20) check("stream_rate", 64'(hs_cyc[19] - hs_cyc[0]), 64'd38);
    check("stream_last_tag", {60'd0, out_tag}, 64'd3);

    // Randomised traffic with random backpressure
    mix = 1'b1;
    rand_or = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send($urandom, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step($urandom_range(1, 4));
      end
    end
    in_valid = 1'b0;
    rand_or = 1'b0;
    step(1);
    out_ready = 1'b1;
    wait_idle();
    check("rand_done", {48'd0, done_count}, 64'd80);
    check("rand_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'd50 + 32'(i), 32'd1, 32'd0);
    in_valid = 1'b0;
    step(2);
    check("mid_ov_before", {63'd0, out_valid}, 64'd1);
    do_reset();
    check("mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_done", {48'd0, done_count}, 64'd0);
    check("mid_alu_a", {32'd0, alu_a}, 64'd0);
    out_ready = 1'b1;
    step(20);
    check("mid_no_stale", {63'd0, busy}, 64'd0);
    send(32'd7, 32'd8, 32'd3);
    in_valid = 1'b0;
    wait_idle();
    check("post_done", {48'd0, done_count}, 64'd1);
    check("post_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
Upstream issue stage for the combinational 32-bit ALU (ports A, B, Op, Result).
- Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Drives registered operands into the ALU one command at a time, then captures Result.
- Presents Result with a sequence tag on a valid/ready output interface.
- Opcode values pass through unmodified; this block never decodes Op.

Parameters:
DATA_W, 32, width of A, B, Result
OP_W, 32, width of Op
DEPTH, 4, command FIFO entries; power of two, >= 2
TAG_W, 4, width of the issue sequence tag

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  command accepted when in_valid && in_ready
in_a  input  DATA_W  operand A
in_b  input  DATA_W  operand B
in_op  input  OP_W  opcode
alu_a  output  DATA_W  to ALU A, registered
alu_b  output  DATA_W  to ALU B, registered
alu_op  output  OP_W  to ALU Op, registered
alu_result  input  DATA_W  from ALU Result, combinational on alu_a/alu_b/alu_op
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid && out_ready
out_result  output  DATA_W  captured ALU result
out_tag  output  TAG_W  issue sequence number of this result
busy  output  1  high when FIFO is non-empty or state != IDLE
done_count  output  16  count of completed output handshakes; wraps at 2^16

Behaviour:
Reset (rst_n low at a clk edge):
- FIFO empty, state IDLE.
- alu_a, alu_b, alu_op, out_result, out_tag, done_count all 0; out_valid 0.
- Consequently in_ready 1 and busy 0 after reset.
- Reset mid-operation discards all buffered and in-flight commands; no partial output appears afterwards.

Input side:
- in_ready = !fifo_full, registered-state based only; no pop-to-push bypass.
- When full, a same-cycle pop does not allow a push.
- Push on in_valid && in_ready; the entry is visible the next cycle.

State machine, three states:
- IDLE: if FIFO non-empty, load head into alu_a/alu_b/alu_op, pop, set out_tag <= issue_cnt, issue_cnt++, go to EXEC. Otherwise stay.
- EXEC: out_result <= alu_result, out_valid <= 1, go to HOLD. The ALU sees stable registered operands for exactly this one cycle before capture.
- HOLD: out_valid held high; out_result and out_tag stable until handshake.
  - On out_valid && out_ready: done_count++.
  - If FIFO non-empty at that edge: load next command (as in IDLE) and go to EXEC; out_valid drops to 0.
  - Otherwise: out_valid <= 0, go to IDLE.
  - With no handshake, stay in HOLD.

Latency and throughput:
- Push at edge N, FIFO previously empty, state IDLE: operands load at edge N+1; out_valid rises at edge N+2.
- Maximum throughput is 1 result per 2 cycles with out_ready tied high.

Other rules:
- alu_a/alu_b/alu_op change only on a load; otherwise they hold their last values.
- issue_cnt is TAG_W wide, resets to 0, and wraps (tag 15 -> 0 for TAG_W=4).
- Results leave in strict command order; no reordering, no drops.
- Simultaneous push and pop: both occur; occupancy is unchanged.

Decomposition:
- Package alu_stage_pkg: DATA_W, OP_W defaults; state enum state_t {IDLE, EXEC, HOLD}.
- Sub-module alu_cmd_fifo: synchronous FIFO, DEPTH x (2*DATA_W+OP_W).
  - Ports: push, pop, wdata, rdata (head, combinational), full, empty.
  - Pointers are log2(DEPTH)+1 bits, so full/empty are distinguished by the wrap bit.
- Top level: FSM, operand/result registers, counters.

Test Plan:
- Single command, bench ALU stub Result=A+B: push a=10, b=5, op=2 at edge 0 -> alu_a=10/alu_b=5/alu_op=2 after edge 1; out_valid=1, out_result=15, out_tag=0 after edge 2; done_count=1 after handshake.
- Backpressure: out_ready=0, push 5 commands back-to-back -> 1 issued, 4 buffered, in_ready=0. A 6th in_valid is not accepted. out_result/out_tag stay stable for 20 cycles.
- Streaming: out_ready=1, 20 commands (a=i, b=2*i) -> results 3*i in order, one out_valid pulse every 2 cycles, tags 0..15,0..3 (wrap), done_count=20.
- Full boundary: FIFO full, release out_ready for one handshake -> in_ready rises the cycle after the pop, not the same cycle.
- Reset mid-stream: 3 commands buffered, out_valid=1, drive rst_n=0 for one edge -> out_valid=0, busy=0, in_ready=1, done_count=0; no stale results ever appear.
- Idle stability: after the last result drains -> state IDLE, busy=0, alu_* hold the last operands unchanged for 10 cycles.
